// File: rtl/dm_wb_cache.sv
// rtl/dm_wb_cache.sv - direct-mapped write-back write-allocate data cache with line-granular memory port
// Optional hit/miss counters (req_cnt, miss_cnt) are built when CACHE_STATS_EN is defined.
module dm_wb_cache #(
   parameter int LINE_ADDR_LEN = 3,
   parameter int SET_ADDR_LEN  = 3,
   parameter int TAG_ADDR_LEN  = 6
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [31:0]                            addr,
   input  logic                                   rd_req,
   output logic [31:0]                            rd_data,
   input  logic                                   wr_req,
   input  logic [31:0]                            wr_data,
   output logic                                   miss,
   input  logic                                   mem_gnt,
   output logic [TAG_ADDR_LEN+SET_ADDR_LEN-1:0]   mem_addr,
   output logic                                   mem_rd_req,
   input  logic [32*(1<<LINE_ADDR_LEN)-1:0]       mem_rd_line,
   output logic                                   mem_wr_req,
   output logic [32*(1<<LINE_ADDR_LEN)-1:0]       mem_wr_line
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]                            req_cnt,
   output logic [31:0]                            miss_cnt
`endif
);

   localparam int SETS   = 1 << SET_ADDR_LEN;
   localparam int LINE_W = 32 * (1 << LINE_ADDR_LEN);
   localparam int ADDR_HI = LINE_ADDR_LEN + SET_ADDR_LEN + TAG_ADDR_LEN + 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SWAP_OUT,
      S_SWAP_IN,
      S_SWAP_IN_OK
   } state_t;

   state_t                                 r_state;
   logic [LINE_W-1:0]                      r_data [SETS];
   logic [TAG_ADDR_LEN-1:0]                r_tag [SETS];
   logic [SETS-1:0]                        r_valid;
   logic [SETS-1:0]                        r_dirty;
   logic [31:0]                            r_rd_data;
   logic                                   r_mem_rd_req;
   logic                                   r_mem_wr_req;
   logic [TAG_ADDR_LEN+SET_ADDR_LEN-1:0]   r_mem_addr;
   logic [SET_ADDR_LEN-1:0]                r_miss_set;
   logic [TAG_ADDR_LEN-1:0]                r_miss_tag;
`ifdef CACHE_STATS_EN
   logic [31:0]                            r_req_cnt;
   logic [31:0]                            r_miss_cnt;
`endif

   logic [LINE_ADDR_LEN-1:0]               w_word;
   logic [SET_ADDR_LEN-1:0]                w_set;
   logic [TAG_ADDR_LEN-1:0]                w_tag;
   logic [LINE_ADDR_LEN+4:0]               w_word_lsb;
   logic                                   w_req;
   logic                                   w_hit;
   logic                                   w_idle_hit;
   logic                                   w_wr_hit;
   logic                                   w_unused;

   assign w_word     = addr[LINE_ADDR_LEN+1:2];
   assign w_set      = addr[LINE_ADDR_LEN+SET_ADDR_LEN+1:LINE_ADDR_LEN+2];
   assign w_tag      = addr[ADDR_HI-1:LINE_ADDR_LEN+SET_ADDR_LEN+2];
   assign w_word_lsb = {w_word, 5'b0};
   assign w_unused   = ^{addr[31:ADDR_HI], addr[1:0]};

   assign w_req      = rd_req | wr_req;
   assign w_hit      = r_valid[w_set] & (r_tag[w_set] == w_tag);
   assign w_idle_hit = w_hit & (r_state == S_IDLE);
   assign w_wr_hit   = w_idle_hit & wr_req & ~rd_req;
   assign miss       = w_req & ~w_idle_hit;

   assign rd_data     = r_rd_data;
   assign mem_rd_req  = r_mem_rd_req;
   assign mem_wr_req  = r_mem_wr_req;
   assign mem_addr    = r_mem_addr;
   // The victim set is latched at miss time, and the array is untouched until refill, so this is stable.
   assign mem_wr_line = r_data[r_miss_set];
`ifdef CACHE_STATS_EN
   assign req_cnt  = r_req_cnt;
   assign miss_cnt = r_miss_cnt;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_valid      <= '0;
         r_dirty      <= '0;
         r_rd_data    <= '0;
         r_mem_rd_req <= 1'b0;
         r_mem_wr_req <= 1'b0;
         r_mem_addr   <= '0;
         r_miss_set   <= '0;
         r_miss_tag   <= '0;
         for (int i = 0; i < SETS; i++) r_tag[i] <= '0;
`ifdef CACHE_STATS_EN
         r_req_cnt    <= '0;
         r_miss_cnt   <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req && w_hit) begin
                  if (rd_req) r_rd_data <= r_data[w_set][w_word_lsb +: 32];
                  else        r_dirty[w_set] <= 1'b1;
`ifdef CACHE_STATS_EN
                  r_req_cnt <= r_req_cnt + 32'd1;
`endif
               end else if (w_req) begin
                  r_miss_set <= w_set;
                  r_miss_tag <= w_tag;
`ifdef CACHE_STATS_EN
                  r_miss_cnt <= r_miss_cnt + 32'd1;
`endif
                  if (r_valid[w_set] && r_dirty[w_set]) begin
                     r_state      <= S_SWAP_OUT;
                     r_mem_wr_req <= 1'b1;
                     r_mem_addr   <= {r_tag[w_set], w_set};
                  end else begin
                     r_state      <= S_SWAP_IN;
                     r_mem_rd_req <= 1'b1;
                     r_mem_addr   <= {w_tag, w_set};
                  end
               end
            end
            S_SWAP_OUT: begin
               if (mem_gnt) begin
                  r_state      <= S_SWAP_IN;
                  r_mem_wr_req <= 1'b0;
                  r_mem_rd_req <= 1'b1;
                  r_mem_addr   <= {r_miss_tag, r_miss_set};
               end
            end
            S_SWAP_IN: begin
               if (mem_gnt) begin
                  r_state      <= S_SWAP_IN_OK;
                  r_mem_rd_req <= 1'b0;
               end
            end
            S_SWAP_IN_OK: begin
               r_tag[r_miss_set]   <= r_miss_tag;
               r_valid[r_miss_set] <= 1'b1;
               r_dirty[r_miss_set] <= 1'b0;
               r_state             <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Line storage has no reset; validity alone decides whether its contents mean anything.
   always_ff @(posedge clk) begin
      if (w_wr_hit)
         r_data[w_set][w_word_lsb +: 32] <= wr_data;
      else if (r_state == S_SWAP_IN_OK)
         r_data[r_miss_set] <= mem_rd_line;
   end

endmodule

// File: doc/dm_wb_cache.md
Name: dm_wb_cache

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU load/store stage and the line-granular main memory model.
- Serves single-word reads and writes on hit, with the hit/miss flag produced the same cycle.
- On miss it stalls the CPU, evicts the line if dirty, then refills the whole line.
- Drives the main memory handshake: address plus request held stable until grant.

Parameters:
- LINE_ADDR_LEN, 3, log2 of words per line; must match main memory.
- SET_ADDR_LEN, 3, log2 of number of lines (sets).
- TAG_ADDR_LEN, 6, tag width; MEM_ADDR_LEN = TAG_ADDR_LEN + SET_ADDR_LEN (default 9).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  32  byte address; [1:0] ignored; word = [LINE_ADDR_LEN+1:2]; set = next SET_ADDR_LEN bits; tag = next TAG_ADDR_LEN bits; upper bits ignored.
- rd_req  in  1  read request.
- rd_data  out  32  read data, registered.
- wr_req  in  1  write request.
- wr_data  in  32  write data.
- miss  out  1  combinational stall flag.
- mem_gnt  in  1  main memory grant.
- mem_addr  out  MEM_ADDR_LEN  line address {tag,set}.
- mem_rd_req  out  1  line read request.
- mem_rd_line  in  32 x 2^LINE_ADDR_LEN  refill line.
- mem_wr_req  out  1  line write request.
- mem_wr_line  out  32 x 2^LINE_ADDR_LEN  victim line.

Behaviour:
- Storage per set: data line, tag, valid, dirty.
- Reset (rst low, async): all valid/dirty = 0, state = IDLE, rd_data = 0, mem_rd_req = mem_wr_req = 0, mem_addr = 0. The data array is not cleared.
- Request arbitration: rd_req has priority when rd_req and wr_req are both high; wr_req is then ignored.
- Requester rule: hold addr, the request and wr_data stable while miss = 1.
- hit = valid[set] & (tag_array[set] == tag).
- miss = (rd_req | wr_req) & ~(hit & state == IDLE).
- States:
  - IDLE:
    - Read hit: rd_data <= line[word] at the edge; valid the next cycle.
    - Write hit: line[word] <= wr_data and dirty <= 1 at the edge.
    - Request and !hit: go to SWAP_OUT if valid & dirty, else SWAP_IN.
  - SWAP_OUT:
    - mem_wr_req = 1, mem_addr = {stored tag, set}, mem_wr_line = stored line, all held constant.
    - On mem_gnt: go to SWAP_IN.
  - SWAP_IN:
    - mem_wr_req = 0, mem_rd_req = 1, mem_addr = {tag, set}.
    - The address change forces main memory to restart its counter; no extra idle cycle is inserted.
    - On mem_gnt: go to SWAP_IN_OK.
  - SWAP_IN_OK:
    - mem_rd_req = 0.
    - line <= mem_rd_line, tag <= tag, valid <= 1, dirty <= 0.
    - Go to IDLE. The held request then hits the cycle after.
- Request outputs are registered/state-decoded: mem_rd_req and mem_wr_req are never high together, and each drops in the cycle after mem_gnt is seen.
- Miss latency: SWAP_OUT and SWAP_IN each take memory latency + 1 cycles, plus 1 cycle for SWAP_IN_OK, plus the hit cycle.
- If the request drops mid-miss, the line transaction in flight still completes and the line is installed.
- Reset mid-operation aborts immediately. A dirty victim whose write had not been granted is lost; this is acceptable for the model.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined: adds output ports req_cnt[31:0] and miss_cnt[31:0], both reset to 0.
  - req_cnt increments on every hit serviced in IDLE.
  - miss_cnt increments on every IDLE->SWAP_OUT or IDLE->SWAP_IN transition.
  - Both wrap at 2^32.
- Undefined: neither port nor the counters exist; behaviour is otherwise identical.

Test Plan:
- Cold read miss:
  - After reset, rd_req addr 0x0000_0104 -> miss = 1 same cycle.
  - mem_rd_req = 1 next cycle with mem_addr = 0x008.
  - Memory refills with word i = 0x100+i -> after grant plus 2 cycles, miss = 0 and rd_data = 0x101.
- Write hit:
  - With the line filled, wr_req addr 0x104 data 0xDEADBEEF -> miss = 0 same cycle, no mem request.
  - Following rd 0x104 -> rd_data = 0xDEADBEEF.
- Dirty eviction:
  - With that line dirty, rd addr 0x204 -> mem_wr_req first, mem_addr = 0x008, mem_wr_line[1] = 0xDEADBEEF.
  - After grant, mem_rd_req with mem_addr = 0x010.
  - mem_wr_req and mem_rd_req are never high together.
- Clean eviction:
  - Read 0x404 when set 0 holds a clean line -> no mem_wr_req; mem_rd_req directly, mem_addr = 0x020.
- Reset mid-refill:
  - rst low during SWAP_IN -> mem_rd_req = 0 immediately, miss reflects invalid cache.
  - After release, re-read 0x104 misses again.
- Stats (CACHE_STATS_EN):
  - Sequence cold miss, 3 hits, dirty miss -> miss_cnt = 2.
  - req_cnt = 5: 3 hits plus 2 post-refill hits.
